trace_event_counter_bank: RTL
=============================

Name: trace_event_counter_bank

Overview:
- Parametrised bank of programmable event counters fed by the core's packed trace-event vector (fetch, decode, instruction mix, branch, load-store, register-file and invalidation events).
- Each counter independently selects one event bit, counts it, flags wrap-around and is readable and writable 32 bits at a time.
- Sits beside the CSR unit and backs the hpmcounter/mhpmevent-style registers and debug performance monitoring.
- Counter count, width and event-vector width are all configurable.

Parameters:
- NUM_COUNTERS, 4, number of independent counters (1..32).
- COUNTER_W, 48, counter width in bits (33..64).
- NUM_EVENTS, 27, width of the event input vector.
- SEL_W (localparam), $clog2(NUM_EVENTS), event-select width.
- IDX_W (localparam), max(1,$clog2(NUM_COUNTERS)), counter-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; the bank is in reset while rst==0.
- events  in  NUM_EVENTS  packed trace events, one bit per event, sampled every cycle.
- freeze  in  1  global count inhibit.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  IDX_W  counter being configured.
- cfg_en  in  1  counter enable value to write.
- cfg_sel  in  SEL_W  event index to write.
- wr_en  in  1  counter value write strobe.
- wr_idx  in  IDX_W  counter being written.
- wr_hi  in  1  0: write bits [31:0]; 1: write bits [COUNTER_W-1:32].
- wr_data  in  32  write data; upper-half writes use the low COUNTER_W-32 bits.
- rd_idx  in  IDX_W  counter being read.
- rd_hi  in  1  read-half select, same encoding as wr_hi.
- rd_data  out  32  registered read data, zero-extended for the upper half.
- ovf_clear  in  NUM_COUNTERS  per-counter overflow clear mask.
- overflow  out  NUM_COUNTERS  sticky wrap flags.
- ovf_irq  out  1  OR-reduction of overflow, registered.

Behaviour:
- Reset (rst==0 at a clock edge) clears all counters, all cfg_en to 0, all cfg_sel to 0, the events_r stage, overflow, rd_data and ovf_irq. Reset asserted mid-count discards all in-flight events.
- Stage 1: events is registered into events_r every cycle.
- Stage 2: counter i increments by 1 when cfg_en[i] && !freeze && events_r[cfg_sel[i]].
  - An event high in cycle t is reflected in the counter after the edge ending cycle t+1.
  - freeze is applied at stage 2, not stage 1.
- cfg_sel >= NUM_EVENTS selects no event, so the counter never increments.
- Wrap: an increment from all-ones yields 0 and sets overflow[i] in the same edge.
- Overflow clear: ovf_clear[i] clears overflow[i]. If the wrap and the clear occur in the same cycle, the set wins.
- ovf_irq is overflow OR-reduced and registered, so it trails overflow by one cycle.
- Counter writes:
  - wr_hi=0 replaces bits [31:0] and keeps the upper bits.
  - wr_hi=1 replaces bits [COUNTER_W-1:32] with wr_data[COUNTER_W-33:0] and keeps the lower bits.
  - If a write and an increment hit the same counter in the same cycle, the write wins and the increment is dropped. No overflow is set from a dropped increment.
- Config writes update cfg_en/cfg_sel on the next edge and never alter the counter value. A config write concurrent with an increment still lets that increment proceed under the old config.
- Read: rd_data is registered with 1-cycle latency and reflects the counter value before the same-edge update.
- Out-of-range indices (idx >= NUM_COUNTERS): writes and config writes are ignored; reads return 0.
- All counters update in parallel; there is no arbitration between counters.

Test Plan:
- Reset then idle: after rst low for 2 cycles and then high, rd_data==0, overflow==0 and ovf_irq==0 for every idx and half; events all ones with every counter disabled leaves every counter at 0.
- Latency: counter 1 with cfg_sel=5, cfg_en=1; pulse events[5] for exactly 3 cycles starting at t. The counter reads 1/2/3 after edges t+2/t+3/t+4 and then holds at 3. A read issued in cycle t+5 returns 3 in cycle t+6.
- Freeze and select: freeze high during a 10-cycle events[5] burst gives +0. cfg_sel=27 (>= NUM_EVENTS) with events all ones gives +0.
- Wrap: write counter 0 to 0xFFFF_FFFF (lo) and 0xFFFF (hi), then one event. Counter becomes 0, overflow[0]=1 on that edge, ovf_irq=1 one cycle later. ovf_clear[0] in the same cycle as a second wrap leaves overflow[0]=1.
- Write collision: counter 2 counting continuously; wr_en with wr_hi=0 and wr_data=0x100. Counter reads exactly 0x100 and reaches 0x101 after the next event edge. Upper-half bits are unchanged after the lo write.
- Out of range: with NUM_COUNTERS=3, wr_idx=3 and cfg_idx=3 writes change no state, and rd_idx=3 returns 0.

Source files
------------

// File: rtl/trace_event_counter_bank.sv
// Bank of programmable event counters fed by the core trace-event vector.
// Two stages: events are registered, then each counter counts its selected bit.
module trace_event_counter_bank #(
  parameter  int NUM_COUNTERS = 4,
  parameter  int COUNTER_W    = 48,
  parameter  int NUM_EVENTS   = 27,
  localparam int SEL_W        = $clog2(NUM_EVENTS),
  localparam int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_EVENTS-1:0]   events,
  input  logic                    freeze,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic                    cfg_en,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic                    wr_hi,
  input  logic [31:0]             wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic                    rd_hi,
  output logic [31:0]             rd_data,
  input  logic [NUM_COUNTERS-1:0] ovf_clear,
  output logic [NUM_COUNTERS-1:0] overflow,
  output logic                    ovf_irq
);

  localparam int EV_PAD_W = 1 << SEL_W;
  localparam int HI_W     = COUNTER_W - 32;

  logic [NUM_EVENTS-1:0]   events_q, events_d;
  logic [COUNTER_W-1:0]    cnt_q [NUM_COUNTERS];
  logic [COUNTER_W-1:0]    cnt_d [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_q [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] en_q, en_d;
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    irq_q, irq_d;
  logic [EV_PAD_W-1:0]     ev_pad;
  logic [COUNTER_W:0]      sum;

  always_comb begin
    events_d  = events;
    // Selects beyond NUM_EVENTS land on zero padding and never count.
    ev_pad    = '0;
    ev_pad[NUM_EVENTS-1:0] = events_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    ovf_d     = ovf_q & ~ovf_clear;
    irq_d     = |ovf_q;
    rd_data_d = '0;
    sum       = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        if (wr_hi) cnt_d[i][COUNTER_W-1:32] = wr_data[HI_W-1:0];
        else       cnt_d[i][31:0]           = wr_data;
      end else if (en_q[i] && !freeze && ev_pad[sel_q[i]]) begin
        sum      = {1'b0, cnt_q[i]} + (COUNTER_W+1)'(1);
        cnt_d[i] = sum[COUNTER_W-1:0];
        if (sum[COUNTER_W]) ovf_d[i] = 1'b1;
      end
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        en_d[i]  = cfg_en;
        sel_d[i] = cfg_sel;
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_data_d = rd_hi ? 32'(cnt_q[i][COUNTER_W-1:32]) : cnt_q[i][31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      events_q  <= '0;
      en_q      <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      events_q  <= events_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign overflow = ovf_q;
  assign ovf_irq  = irq_q;

endmodule
